// File: rtl/pwlock_ctrl_if.sv
// pwlock_ctrl_if - command/status bundle between the command decoder,
// the password-lock controller and the status display logic.
//   master : command decoder side (drives pulses, observes status)
//   slave  : pwlock_ctrl side (consumes pulses, drives status)
// Commands : start, entry_valid/entry_data, check, set_pw, exit (1-cycle pulses)
// Status   : state, unlocked, err_pulse, lockout, remaining, tries_left, prog_done
interface pwlock_ctrl_if #(
  parameter int DW = 8,   // digit width
  parameter int RW = 6,   // width of remaining, $clog2(LOCK_TICKS+1)
  parameter int TW = 2    // width of tries_left, $clog2(MAX_TRIES+1)
);
  logic          start;
  logic          entry_valid;
  logic [DW-1:0] entry_data;
  logic          check;
  logic          set_pw;
  logic          exit;
  logic [2:0]    state;
  logic          unlocked;
  logic          err_pulse;
  logic          lockout;
  logic [RW-1:0] remaining;
  logic [TW-1:0] tries_left;
  logic          prog_done;

  modport master (
    output start, entry_valid, entry_data, check, set_pw, exit,
    input  state, unlocked, err_pulse, lockout, remaining, tries_left, prog_done
  );

  modport slave (
    input  start, entry_valid, entry_data, check, set_pw, exit,
    output state, unlocked, err_pulse, lockout, remaining, tries_left, prog_done
  );
endinterface

// File: rtl/pwlock_ctrl.sv
// pwlock_ctrl - parametrised password-lock controller with retry limit,
// timed lockout and in-field password reprogramming.
// Ports:
//   clk  : system clock (lockout ticks are divided down from it)
//   rst  : asynchronous, active-high reset
//   bus  : pwlock_ctrl_if.slave - command pulses in, registered status out
// Every status output is a flop or a decode of flops; no input reaches an
// output combinationally.
module pwlock_ctrl #(
  parameter int                     DW           = 8,
  parameter int                     PW_LEN       = 3,
  parameter logic [DW*PW_LEN-1:0]   PW_INIT      = {(DW*PW_LEN){1'b0}},
  parameter int                     MAX_TRIES    = 3,
  parameter int                     LOCK_TICKS   = 60,
  parameter int                     CLK_PER_TICK = 100000000
) (
  input  logic         clk,
  input  logic         rst,
  pwlock_ctrl_if.slave bus
);

  localparam int PWW = DW * PW_LEN;
  localparam int RW  = $clog2(LOCK_TICKS + 1);
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int IW  = $clog2(PW_LEN + 1);
  localparam int DVW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  localparam logic [IW-1:0]  LEN_C      = IW'(PW_LEN);
  localparam logic [IW-1:0]  LAST_C     = IW'(PW_LEN - 1);
  localparam logic [TW-1:0]  TRIES_C    = TW'(MAX_TRIES);
  localparam logic [RW-1:0]  TICKS_C    = RW'(LOCK_TICKS);
  localparam logic [DVW-1:0] DIV_LAST_C = DVW'(CLK_PER_TICK - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOCKED   = 3'd1;
  localparam logic [2:0] S_ERROR    = 3'd2;
  localparam logic [2:0] S_LOCKOUT  = 3'd3;
  localparam logic [2:0] S_UNLOCKED = 3'd4;
  localparam logic [2:0] S_PROGRAM  = 3'd5;

  // Digit i of a packed password vector (digit 0 in the low bits).
  function automatic logic [DW-1:0] pw_digit(input logic [PWW-1:0] vec, input logic [IW-1:0] i);
    logic [DW-1:0] d;
    d = {DW{1'b0}};
    for (int k = 0; k < PW_LEN; k++) begin
      d = (i == IW'(k)) ? vec[k*DW +: DW] : d;
    end
    return d;
  endfunction

  // Copy of vec with digit i replaced by val.
  function automatic logic [PWW-1:0] put_digit(input logic [PWW-1:0] vec, input logic [IW-1:0] i,
                                               input logic [DW-1:0] val);
    logic [PWW-1:0] r;
    r = vec;
    for (int k = 0; k < PW_LEN; k++) begin
      r[k*DW +: DW] = (i == IW'(k)) ? val : vec[k*DW +: DW];
    end
    return r;
  endfunction

  logic [2:0]     state_q,    state_d;
  logic [IW-1:0]  idx_q,      idx_d;
  logic           match_q,    match_d;
  logic           ovf_q,      ovf_d;
  logic [TW-1:0]  tries_q,    tries_d;   // MAX_TRIES - fail_cnt, kept directly
  logic [RW-1:0]  rem_q,      rem_d;
  logic [DVW-1:0] div_q,      div_d;
  logic [PWW-1:0] pw_q,       pw_d;
  logic [PWW-1:0] shadow_q,   shadow_d;
  logic           err_q,      err_d;
  logic           done_q,     done_d;
  logic           unlocked_q, unlocked_d;
  logic           lockout_q,  lockout_d;

  // One command per cycle: exit > set_pw > check > entry_valid.
  logic cmd_exit_s, cmd_set_s, cmd_check_s, cmd_entry_s, pass_s;
  logic [PWW-1:0] shadow_next_s;

  assign cmd_exit_s  = bus.exit;
  assign cmd_set_s   = !bus.exit && bus.set_pw;
  assign cmd_check_s = !bus.exit && !bus.set_pw && bus.check;
  assign cmd_entry_s = !bus.exit && !bus.set_pw && !bus.check && bus.entry_valid;

  // Next-state and datapath decisions for all controller states.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    match_d       = match_q;
    ovf_d         = ovf_q;
    tries_d       = tries_q;
    rem_d         = rem_q;
    div_d         = div_q;
    pw_d          = pw_q;
    shadow_d      = shadow_q;
    err_d         = 1'b0;
    done_d        = 1'b0;
    pass_s        = (idx_q == LEN_C) && match_q && !ovf_q;
    shadow_next_s = put_digit(shadow_q, idx_q, bus.entry_data);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOCKED;
          idx_d   = {IW{1'b0}};
          match_d = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (cmd_check_s) begin
          // attempt state is re-armed whatever the outcome
          idx_d   = {IW{1'b0}};
          match_d = 1'b1;
          ovf_d   = 1'b0;
          if (pass_s) begin
            state_d = S_UNLOCKED;
            tries_d = TRIES_C;
          end else if (tries_q == TW'(1)) begin
            state_d = S_LOCKOUT;
            tries_d = TRIES_C;
            rem_d   = TICKS_C;
            div_d   = {DVW{1'b0}};
            err_d   = 1'b1;
          end else begin
            state_d = S_ERROR;
            tries_d = tries_q - 1'b1;
            err_d   = 1'b1;
          end
        end else if (cmd_entry_s) begin
          if (idx_q < LEN_C) begin
            match_d = match_q & (bus.entry_data == pw_digit(pw_q, idx_q));
            idx_d   = idx_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = S_LOCKED;
        end
      end
      S_ERROR: begin
        state_d = S_LOCKED;
      end
      S_LOCKOUT: begin
        if (div_q == DIV_LAST_C) begin
          div_d = {DVW{1'b0}};
          if (rem_q == RW'(1)) begin
            state_d = S_LOCKED;
            rem_d   = {RW{1'b0}};
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_UNLOCKED: begin
        if (cmd_exit_s) begin
          state_d = S_LOCKED;
          idx_d   = {IW{1'b0}};
          match_d = 1'b1;
          ovf_d   = 1'b0;
        end else if (cmd_set_s) begin
          state_d = S_PROGRAM;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = S_UNLOCKED;
        end
      end
      S_PROGRAM: begin
        if (cmd_exit_s) begin
          // abort: shadow is discarded, pw untouched
          state_d = S_UNLOCKED;
          idx_d   = {IW{1'b0}};
        end else if (cmd_entry_s) begin
          shadow_d = shadow_next_s;
          if (idx_q == LAST_C) begin
            pw_d    = shadow_next_s;  // whole password swaps in one edge
            done_d  = 1'b1;
            state_d = S_UNLOCKED;
            idx_d   = {IW{1'b0}};
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = S_PROGRAM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
    lockout_d  = (state_d == S_LOCKOUT);
  end

  // State, datapath and registered status flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= {IW{1'b0}};
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tries_q    <= TRIES_C;
      rem_q      <= {RW{1'b0}};
      div_q      <= {DVW{1'b0}};
      pw_q       <= PW_INIT;
      shadow_q   <= {PWW{1'b0}};
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      tries_q    <= tries_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      pw_q       <= pw_d;
      shadow_q   <= shadow_d;
      err_q      <= err_d;
      done_q     <= done_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.err_pulse  = err_q;
  assign bus.lockout    = lockout_q;
  assign bus.remaining  = rem_q;
  assign bus.tries_left = tries_q;
  assign bus.prog_done  = done_q;

endmodule

// File: tb/tb_pwlock_ctrl.sv
// tb_pwlock_ctrl - scoreboard bench for pwlock_ctrl. Stimulus steps push the
// status values they should produce (with the cycle they must appear in) and
// a negedge monitor pops and compares them.
module tb_pwlock_ctrl;
  localparam int DW           = 8;
  localparam int PW_LEN       = 3;
  localparam int MAX_TRIES    = 3;
  localparam int LOCK_TICKS   = 4;
  localparam int CLK_PER_TICK = 5;
  localparam int RW           = $clog2(LOCK_TICKS + 1);
  localparam int TW           = $clog2(MAX_TRIES + 1);
  localparam logic [23:0] PW_INIT = {8'h03, 8'h02, 8'h01};

  localparam int F_ST  = 0;
  localparam int F_UNL = 1;
  localparam int F_ERR = 2;
  localparam int F_LO  = 3;
  localparam int F_REM = 4;
  localparam int F_TL  = 5;
  localparam int F_PD  = 6;

  typedef struct {
    string tag;
    int    at;
    int    fld;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  pwlock_ctrl_if #(.DW(DW), .RW(RW), .TW(TW)) bus ();

  pwlock_ctrl #(
    .DW(DW), .PW_LEN(PW_LEN), .PW_INIT(PW_INIT), .MAX_TRIES(MAX_TRIES),
    .LOCK_TICKS(LOCK_TICKS), .CLK_PER_TICK(CLK_PER_TICK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int read_fld(input int fld);
    case (fld)
      F_ST:    return int'(bus.state);
      F_UNL:   return int'(bus.unlocked);
      F_ERR:   return int'(bus.err_pulse);
      F_LO:    return int'(bus.lockout);
      F_REM:   return int'(bus.remaining);
      F_TL:    return int'(bus.tries_left);
      F_PD:    return int'(bus.prog_done);
      default: return -1;
    endcase
  endfunction

  // Scoreboard monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].at == cyc) begin
        check_eq(sb_q[i].tag, read_fld(sb_q[i].fld), sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_in(input string tag, input int fld, input int val, input int dly);
    exp_t e;
    e.tag = tag;
    e.at  = cyc + dly;
    e.fld = fld;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic clr();
    bus.start = 1'b0; bus.entry_valid = 1'b0; bus.entry_data = 8'h00;
    bus.check = 1'b0; bus.set_pw = 1'b0; bus.exit = 1'b0;
  endtask

  // Drive one cycle of inputs, return at the following negedge.
  task automatic step(input logic s, input logic ev, input logic [7:0] d,
                      input logic ck, input logic sp, input logic ex);
    bus.start = s; bus.entry_valid = ev; bus.entry_data = d;
    bus.check = ck; bus.set_pw = sp; bus.exit = ex;
    @(negedge clk);
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic entry(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    entry(a); entry(b); entry(c);
  endtask

  task automatic do_start();  step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_check();  step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_setpw();  step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); endtask
  task automatic do_exit();   step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); endtask

  // Enter a password and check it, expecting UNLOCKED with a full retry budget.
  task automatic unlock(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    enter3(a, b, c);
    expect_in({tag, "_state"}, F_ST, 4, 1);
    expect_in({tag, "_unl"}, F_UNL, 1, 1);
    expect_in({tag, "_tl"}, F_TL, 3, 1);
    expect_in({tag, "_err"}, F_ERR, 0, 1);
    do_check();
  endtask

  // Failing check (optionally with a same-cycle entry that must be dropped).
  task automatic fail_check(input string tag, input int tl, input logic with_entry, input logic [7:0] d);
    expect_in({tag, "_err"}, F_ERR, 1, 1);
    expect_in({tag, "_state"}, F_ST, 2, 1);
    expect_in({tag, "_tl"}, F_TL, tl, 1);
    expect_in({tag, "_state2"}, F_ST, 1, 2);
    expect_in({tag, "_err2"}, F_ERR, 0, 2);
    step(1'b0, with_entry, d, 1'b1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic reset_expect(input string tag);
    expect_in({tag, "_state"}, F_ST, 0, 1);
    expect_in({tag, "_unl"}, F_UNL, 0, 1);
    expect_in({tag, "_err"}, F_ERR, 0, 1);
    expect_in({tag, "_lo"}, F_LO, 0, 1);
    expect_in({tag, "_rem"}, F_REM, 0, 1);
    expect_in({tag, "_tl"}, F_TL, 3, 1);
    expect_in({tag, "_pd"}, F_PD, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clr();
    rst = 1'b1;
    idle(2);
    reset_expect("rst0");
    idle(1);
    rst = 1'b0;
    idle(1);

    // correct password
    expect_in("start_state", F_ST, 1, 1);
    do_start();
    unlock("t1", 8'h01, 8'h02, 8'h03);
    expect_in("t1_exit_state", F_ST, 1, 1);
    expect_in("t1_exit_unl", F_UNL, 0, 1);
    do_exit();

    // short entry, then overflow entry
    entry(8'h01); entry(8'h02);
    fail_check("t2_short", 2, 1'b0, 8'h00);
    enter3(8'h01, 8'h02, 8'h03); entry(8'h04);
    fail_check("t2_ovf", 1, 1'b0, 8'h00);

    // third failure enters lockout
    entry(8'h05);
    base = cyc;
    expect_in("lo_state", F_ST, 3, 1);
    expect_in("lo_flag", F_LO, 1, 1);
    expect_in("lo_rem4", F_REM, 4, 1);
    expect_in("lo_err", F_ERR, 1, 1);
    expect_in("lo_tl", F_TL, 3, 1);
    expect_in("lo_err_off", F_ERR, 0, 2);
    expect_in("lo_rem4_end", F_REM, 4, 5);
    expect_in("lo_rem3", F_REM, 3, 6);
    expect_in("lo_rem2", F_REM, 2, 11);
    expect_in("lo_rem1", F_REM, 1, 16);
    expect_in("lo_last_state", F_ST, 3, 20);
    expect_in("lo_exit_state", F_ST, 1, 21);
    expect_in("lo_exit_flag", F_LO, 0, 21);
    expect_in("lo_exit_rem", F_REM, 0, 21);
    do_check();
    // inputs during lockout must be ignored
    enter3(8'h01, 8'h02, 8'h03);
    expect_in("lo_ign_state", F_ST, 3, 1);
    expect_in("lo_ign_err", F_ERR, 0, 1);
    do_check();
    do_start();
    idle(base + 21 - cyc);
    unlock("t3_after", 8'h01, 8'h02, 8'h03);

    // reprogram to AA,BB,CC
    expect_in("pg_state", F_ST, 5, 1);
    expect_in("pg_unl", F_UNL, 1, 1);
    do_setpw();
    expect_in("pg_mid_state", F_ST, 5, 1);
    expect_in("pg_mid_pd", F_PD, 0, 1);
    entry(8'hAA); entry(8'hBB);
    expect_in("pg_done", F_PD, 1, 1);
    expect_in("pg_done_state", F_ST, 4, 1);
    expect_in("pg_done_off", F_PD, 0, 2);
    entry(8'hCC);
    do_exit();
    unlock("t4_new", 8'hAA, 8'hBB, 8'hCC);
    do_exit();
    enter3(8'h01, 8'h02, 8'h03);
    fail_check("t4_old", 2, 1'b0, 8'h00);
    unlock("t4_new2", 8'hAA, 8'hBB, 8'hCC);

    // abort programming
    do_setpw();
    entry(8'h11);
    expect_in("ab_state", F_ST, 4, 1);
    expect_in("ab_pd", F_PD, 0, 1);
    do_exit();
    expect_in("ab_exit_state", F_ST, 1, 1);
    do_exit();
    unlock("t5_abort", 8'hAA, 8'hBB, 8'hCC);
    do_exit();

    // check beats a same-cycle entry
    entry(8'hAA); entry(8'hBB);
    fail_check("t5_prio", 2, 1'b1, 8'hCC);
    unlock("t5_after", 8'hAA, 8'hBB, 8'hCC);
    do_exit();

    // reset during lockout
    fail_check("t6_f1", 2, 1'b0, 8'h00);
    fail_check("t6_f2", 1, 1'b0, 8'h00);
    expect_in("t6_lo_state", F_ST, 3, 1);
    do_check();
    idle(3);
    rst = 1'b1;
    reset_expect("rst_lo");
    idle(1);
    rst = 1'b0;
    do_start();
    unlock("t6_init", 8'h01, 8'h02, 8'h03);

    // reset during programming: partial password never commits
    do_setpw();
    entry(8'h11); entry(8'h22);
    rst = 1'b1;
    reset_expect("rst_pg");
    idle(1);
    rst = 1'b0;
    do_start();
    unlock("t6_prog", 8'h01, 8'h02, 8'h03);

    idle(3);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
